// File: rtl/gppcu_pkg.sv
// Shared encodings for the GPPCU SIMD core: condition codes, opcodes,
// instruction field positions and register-file geometry.
package gppcu_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;

    localparam int unsigned COND_MSB = 31;
    localparam int unsigned COND_LSB = 28;
    localparam int unsigned OPC_MSB  = 27;
    localparam int unsigned OPC_LSB  = 23;
    localparam int unsigned S_BIT    = 22;
    localparam int unsigned RD_MSB   = 21;
    localparam int unsigned RD_LSB   = 17;
    localparam int unsigned IMM_MSB  = 16;
    localparam int unsigned RA_MSB   = 16;
    localparam int unsigned RA_LSB   = 12;
    localparam int unsigned RB_MSB   = 11;
    localparam int unsigned RB_LSB   = 7;
    localparam int unsigned OFS_MSB  = 11;
    localparam int unsigned OFS_LSB  = 5;
    localparam int unsigned BASE_MSB = 4;
    localparam int unsigned BASE_LSB = 0;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_EQ = 4'd1,
        COND_NE = 4'd2,
        COND_MI = 4'd3,
        COND_PL = 4'd4
    } cond_e;

    typedef enum logic [4:0] {
        OPC_NOP = 5'd0,
        OPC_MVI = 5'd1,
        OPC_ADD = 5'd2,
        OPC_SUB = 5'd3,
        OPC_AND = 5'd4,
        OPC_OR  = 5'd5,
        OPC_XOR = 5'd6,
        OPC_LSL = 5'd7,
        OPC_LSR = 5'd8,
        OPC_LDL = 5'd9,
        OPC_STL = 5'd10,
        OPC_LDG = 5'd11,
        OPC_TID = 5'd12
    } opc_e;

    // Unlisted condition codes behave as ALWAYS.
    function automatic logic cond_pass(input logic [3:0] cond, input logic z, input logic n);
        case (cond_e'(cond))
            COND_EQ: return z;
            COND_NE: return !z;
            COND_MI: return n;
            COND_PL: return !n;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/gppcu_thread_lane.sv
// One SIMD lane: register file, Z/N flags, ALU and private local memory.
// Loads are staged here and retired when the core signals write-back.
module gppcu_thread_lane
    import gppcu_pkg::*;
#(
    parameter int unsigned WORD_BW = 9,
    parameter int unsigned LANE_ID = 0
) (
    input  logic               iACLK,
    input  logic               inRST,
    input  logic               issue,
    input  logic [31:0]        instr,
    input  logic               wb_en,
    input  logic               wb_global,
    input  logic [31:0]        gmem_data,
    input  logic               host_we,
    input  logic [WORD_BW-1:0] host_addr,
    input  logic [31:0]        host_wdata,
    output logic [31:0]        host_rdata
);

    localparam int unsigned DEPTH = 1 << WORD_BW;

    logic [31:0]        regs [NUM_REGS];
    logic [31:0]        lmem [DEPTH];
    logic               flag_z;
    logic               flag_n;
    logic               pend_en;
    logic [REG_AW-1:0]  pend_rd;
    logic [31:0]        ld_data;

    logic [3:0]         cond;
    opc_e               opc;
    logic               set_flags;
    logic [REG_AW-1:0]  rd;
    logic [REG_AW-1:0]  ra;
    logic [REG_AW-1:0]  rb;
    logic [REG_AW-1:0]  base;
    logic [16:0]        imm;
    logic [6:0]         ofs;
    logic [31:0]        op_a;
    logic [31:0]        op_b;
    logic [31:0]        alu_res;
    logic               alu_op;
    logic               do_issue;
    logic [WORD_BW-1:0] lm_addr;

    always_comb begin
        cond      = instr[COND_MSB:COND_LSB];
        opc       = opc_e'(instr[OPC_MSB:OPC_LSB]);
        set_flags = instr[S_BIT];
        rd        = instr[RD_MSB:RD_LSB];
        imm       = instr[IMM_MSB:0];
        ra        = instr[RA_MSB:RA_LSB];
        rb        = instr[RB_MSB:RB_LSB];
        ofs       = instr[OFS_MSB:OFS_LSB];
        base      = instr[BASE_MSB:BASE_LSB];
        op_a      = regs[ra];
        op_b      = regs[rb];
        lm_addr   = WORD_BW'(regs[base] + 32'(ofs));
        do_issue  = issue && cond_pass(cond, flag_z, flag_n);
        alu_op    = 1'b1;
        alu_res   = '0;
        case (opc)
            OPC_ADD: alu_res = op_a + op_b;
            OPC_SUB: alu_res = op_a - op_b;
            OPC_AND: alu_res = op_a & op_b;
            OPC_OR:  alu_res = op_a | op_b;
            OPC_XOR: alu_res = op_a ^ op_b;
            OPC_LSL: alu_res = op_a << op_b[4:0];
            OPC_LSR: alu_res = op_a >> op_b[4:0];
            default: alu_op  = 1'b0;
        endcase
    end

    // Write-back and issue never coincide: the core holds READY low during a load.
    always_ff @(posedge iACLK) begin
        if (!inRST) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            pend_en <= 1'b0;
            pend_rd <= '0;
            ld_data <= '0;
        end else begin
            if (wb_en) begin
                pend_en <= 1'b0;
                if (pend_en) regs[pend_rd] <= wb_global ? gmem_data : ld_data;
            end
            if (do_issue) begin
                if (alu_op) begin
                    regs[rd] <= alu_res;
                    if (set_flags) begin
                        flag_z <= (alu_res == '0);
                        flag_n <= alu_res[31];
                    end
                end
                case (opc)
                    OPC_MVI: regs[rd] <= {15'd0, imm};
                    OPC_TID: regs[rd] <= 32'(LANE_ID);
                    OPC_LDL: begin
                        pend_en <= 1'b1;
                        pend_rd <= rd;
                        ld_data <= lmem[lm_addr];
                    end
                    OPC_LDG: begin
                        pend_en <= 1'b1;
                        pend_rd <= rd;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Core store is written last so it overrides a host write to the same word.
    always_ff @(posedge iACLK) begin
        if (host_we) lmem[host_addr] <= host_wdata;
        if (do_issue && opc == OPC_STL) lmem[lm_addr] <= op_a;
    end

    assign host_rdata = lmem[host_addr];

endmodule

// File: rtl/gppcu_simd_core.sv
// Lock-step SIMD core: instruction handshake, one-cycle load stall,
// global-memory fetch and host access to the per-thread local memories.
module gppcu_simd_core
    import gppcu_pkg::*;
#(
    parameter int unsigned NUM_THREAD = 24,
    parameter int unsigned WORD_BW    = 9
) (
    input  logic        iACLK,
    input  logic        inRST,
    input  logic [31:0] iINSTR,
    input  logic        iINSTR_VALID,
    output logic        oINSTR_READY,
    output logic        oIDLING,
    input  logic [7:0]  iLMEM_THREAD_SEL,
    input  logic [15:0] iLMEM_ADDR,
    input  logic [31:0] iLMEM_WDATA,
    input  logic        iLMEM_RD,
    input  logic        iLMEM_WR,
    output logic [31:0] oLMEM_RDATA,
    output logic [16:0] oGMEM_ADDR,
    output logic        oGMEM_RD,
    input  logic [31:0] iGMEM_WDATA
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDL_WAIT,
        ST_LDG_WAIT
    } state_e;

    state_e      state;
    logic        accept;
    opc_e        core_opc;
    logic [16:0] gmem_addr;
    logic        gmem_rd;
    logic [31:0] lmem_rdata;
    logic [31:0] host_sel_rdata;
    logic        wb_en;
    logic        wb_global;
    logic [31:0] lane_hrdata [NUM_THREAD];

    assign core_opc     = opc_e'(iINSTR[OPC_MSB:OPC_LSB]);
    assign oINSTR_READY = inRST && (state == ST_RUN);
    assign oIDLING      = !inRST || (state == ST_RUN && !iINSTR_VALID);
    assign accept       = iINSTR_VALID && oINSTR_READY;
    assign wb_en        = (state != ST_RUN);
    assign wb_global    = (state == ST_LDG_WAIT);
    assign oGMEM_ADDR   = gmem_addr;
    assign oGMEM_RD     = gmem_rd;
    assign oLMEM_RDATA  = lmem_rdata;

    always_ff @(posedge iACLK) begin
        if (!inRST) begin
            state      <= ST_RUN;
            gmem_addr  <= '0;
            gmem_rd    <= 1'b0;
            lmem_rdata <= '0;
        end else begin
            gmem_rd <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (accept && core_opc == OPC_LDL) begin
                        state <= ST_LDL_WAIT;
                    end else if (accept && core_opc == OPC_LDG) begin
                        state     <= ST_LDG_WAIT;
                        gmem_rd   <= 1'b1;
                        gmem_addr <= iINSTR[IMM_MSB:0];
                    end
                end
                default: state <= ST_RUN;
            endcase
            if (iLMEM_RD) lmem_rdata <= host_sel_rdata;
        end
    end

    // Out-of-range selects match no lane and therefore read as zero.
    always_comb begin
        host_sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_THREAD; i++) begin
            if (iLMEM_THREAD_SEL == 8'(i)) host_sel_rdata = lane_hrdata[i];
        end
    end

    for (genvar g = 0; g < NUM_THREAD; g++) begin : g_lane
        gppcu_thread_lane #(
            .WORD_BW (WORD_BW),
            .LANE_ID (g)
        ) u_lane (
            .iACLK      (iACLK),
            .inRST      (inRST),
            .issue      (accept),
            .instr      (iINSTR),
            .wb_en      (wb_en),
            .wb_global  (wb_global),
            .gmem_data  (iGMEM_WDATA),
            .host_we    (iLMEM_WR && (iLMEM_THREAD_SEL == 8'(g))),
            .host_addr  (iLMEM_ADDR[WORD_BW-1:0]),
            .host_wdata (iLMEM_WDATA),
            .host_rdata (lane_hrdata[g])
        );
    end

endmodule

// File: tb/tb_gppcu_simd_core.sv
// Bench for gppcu_simd_core: directed scenarios plus random instruction
// streams checked against an instruction-level model of every thread.
module tb_gppcu_simd_core;

    localparam int NT    = 2;
    localparam int WB    = 9;
    localparam int DEPTH = 512;

    logic        iACLK = 1'b0;
    logic        inRST = 1'b0;
    logic [31:0] iINSTR = '0;
    logic        iINSTR_VALID = 1'b0;
    logic        oINSTR_READY;
    logic        oIDLING;
    logic [7:0]  iLMEM_THREAD_SEL = '0;
    logic [15:0] iLMEM_ADDR = '0;
    logic [31:0] iLMEM_WDATA = '0;
    logic        iLMEM_RD = 1'b0;
    logic        iLMEM_WR = 1'b0;
    logic [31:0] oLMEM_RDATA;
    logic [16:0] oGMEM_ADDR;
    logic        oGMEM_RD;
    logic [31:0] iGMEM_WDATA = '0;

    gppcu_simd_core #(.NUM_THREAD(NT), .WORD_BW(WB)) dut (
        .iACLK            (iACLK),
        .inRST            (inRST),
        .iINSTR           (iINSTR),
        .iINSTR_VALID     (iINSTR_VALID),
        .oINSTR_READY     (oINSTR_READY),
        .oIDLING          (oIDLING),
        .iLMEM_THREAD_SEL (iLMEM_THREAD_SEL),
        .iLMEM_ADDR       (iLMEM_ADDR),
        .iLMEM_WDATA      (iLMEM_WDATA),
        .iLMEM_RD         (iLMEM_RD),
        .iLMEM_WR         (iLMEM_WR),
        .oLMEM_RDATA      (oLMEM_RDATA),
        .oGMEM_ADDR       (oGMEM_ADDR),
        .oGMEM_RD         (oGMEM_RD),
        .iGMEM_WDATA      (iGMEM_WDATA)
    );

    always #5 iACLK = ~iACLK;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_reg [NT][32];
    logic        m_z   [NT];
    logic        m_n   [NT];
    logic [31:0] m_mem [NT][DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] cond, input logic [4:0] opc,
                                        input logic s, input logic [4:0] rd, input logic [16:0] imm);
        return {cond, opc, s, rd, imm};
    endfunction

    function automatic logic [16:0] alu_f(input logic [4:0] ra, input logic [4:0] rb);
        return {ra, rb, 7'd0};
    endfunction

    function automatic logic [16:0] ls_f(input logic [4:0] rs, input logic [6:0] ofs, input logic [4:0] base);
        return {rs, ofs, base};
    endfunction

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            for (int r = 0; r < 32; r++) m_reg[t][r] = '0;
            m_z[t] = 1'b0;
            m_n[t] = 1'b0;
        end
    endtask

    // Architectural effect of one accepted instruction on every thread.
    task automatic model_exec(input logic [31:0] ins, input logic [31:0] gdata);
        int cond, op, rd, ra, rb, rs, ofs, base, adr;
        logic s, pass, is_alu;
        logic [31:0] a, b, res;
        cond = int'(ins[31:28]); op = int'(ins[27:23]); s = ins[22]; rd = int'(ins[21:17]);
        ra = int'(ins[16:12]); rb = int'(ins[11:7]); rs = ra;
        ofs = int'(ins[11:5]); base = int'(ins[4:0]);
        for (int t = 0; t < NT; t++) begin
            case (cond)
                1: pass = m_z[t];
                2: pass = !m_z[t];
                3: pass = m_n[t];
                4: pass = !m_n[t];
                default: pass = 1'b1;
            endcase
            if (!pass) continue;
            a = m_reg[t][ra];
            b = m_reg[t][rb];
            adr = int'((m_reg[t][base] + 32'(ofs)) % DEPTH);
            is_alu = (op >= 2 && op <= 8);
            res = '0;
            case (op)
                2: res = a + b;
                3: res = a - b;
                4: res = a & b;
                5: res = a | b;
                6: res = a ^ b;
                7: res = a << (b % 32);
                8: res = a >> (b % 32);
                default: ;
            endcase
            if (is_alu) begin
                m_reg[t][rd] = res;
                if (s) begin
                    m_z[t] = (res == 0);
                    m_n[t] = res[31];
                end
            end
            case (op)
                1:  m_reg[t][rd] = 32'(ins[16:0]);
                9:  m_reg[t][rd] = m_mem[t][adr];
                10: m_mem[t][adr] = m_reg[t][rs];
                11: m_reg[t][rd] = gdata;
                12: m_reg[t][rd] = 32'(t);
                default: ;
            endcase
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] gdata);
        logic [4:0] op;
        op = ins[27:23];
        @(negedge iACLK);
        iINSTR = ins;
        iINSTR_VALID = 1'b1;
        #1;
        chk("ready_before_accept", 32'(oINSTR_READY), 32'd1);
        chk("idle_with_valid", 32'(oIDLING), 32'd0);
        @(posedge iACLK);
        #1;
        iINSTR_VALID = 1'b0;
        iINSTR = $urandom;
        model_exec(ins, gdata);
        if (op == 5'd9 || op == 5'd11) begin
            chk("ready_low_in_stall", 32'(oINSTR_READY), 32'd0);
            chk("idle_low_in_stall", 32'(oIDLING), 32'd0);
            chk("gmem_rd_in_stall", 32'(oGMEM_RD), (op == 5'd11) ? 32'd1 : 32'd0);
            if (op == 5'd11) begin
                chk("gmem_addr", 32'(oGMEM_ADDR), 32'(ins[16:0]));
                iGMEM_WDATA = gdata;
            end
            @(posedge iACLK);
            #1;
            iGMEM_WDATA = $urandom;
            chk("ready_after_stall", 32'(oINSTR_READY), 32'd1);
        end
        chk("gmem_rd_idle", 32'(oGMEM_RD), 32'd0);
    endtask

    task automatic idle_cycle();
        @(negedge iACLK);
        iINSTR = $urandom;
        iINSTR_VALID = 1'b0;
        #1;
        chk("idle_no_valid", 32'(oIDLING), 32'd1);
        @(posedge iACLK);
        #1;
    endtask

    task automatic host_write(input int sel, input int addr, input logic [31:0] data);
        @(negedge iACLK);
        iLMEM_THREAD_SEL = 8'(sel);
        iLMEM_ADDR = 16'(addr);
        iLMEM_WDATA = data;
        iLMEM_WR = 1'b1;
        @(posedge iACLK);
        #1;
        iLMEM_WR = 1'b0;
        if (sel < NT) m_mem[sel][addr % DEPTH] = data;
    endtask

    task automatic host_read_chk(input string tag, input int sel, input int addr, input logic [31:0] exp);
        @(negedge iACLK);
        iLMEM_THREAD_SEL = 8'(sel);
        iLMEM_ADDR = 16'(addr);
        iLMEM_RD = 1'b1;
        @(posedge iACLK);
        #1;
        iLMEM_RD = 1'b0;
        chk(tag, oLMEM_RDATA, exp);
    endtask

    task automatic dump_regs();
        for (int r = 0; r < 32; r++) issue(enc(4'd0, 5'd10, 1'b0, 5'd0, ls_f(5'(r), 7'(r), 5'd0)), '0);
    endtask

    task automatic compare_all_mem();
        for (int t = 0; t < NT; t++)
            for (int a = 0; a < DEPTH; a++) host_read_chk("lmem_vs_model", t, a, m_mem[t][a]);
    endtask

    task automatic random_phase(input int n);
        logic [31:0] ins;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                idle_cycle();
            end else begin
                ins = enc(4'($urandom_range(0, 7)), 5'($urandom_range(0, 15)), 1'($urandom),
                          5'($urandom), 17'($urandom));
                issue(ins, $urandom);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_shift [4];
        logic [31:0] ins;
        exp_shift[0] = 32'd176;
        exp_shift[1] = 32'd2816;
        exp_shift[2] = 32'd45056;
        exp_shift[3] = 32'd720896;

        // Reset state, including a valid instruction offered during reset.
        iINSTR = enc(4'd0, 5'd1, 1'b0, 5'd1, 17'd5);
        iINSTR_VALID = 1'b1;
        repeat (3) @(posedge iACLK);
        #1;
        chk("rst_ready", 32'(oINSTR_READY), 32'd0);
        chk("rst_idle", 32'(oIDLING), 32'd1);
        chk("rst_gmem_rd", 32'(oGMEM_RD), 32'd0);
        chk("rst_gmem_addr", 32'(oGMEM_ADDR), 32'd0);
        chk("rst_rdata", oLMEM_RDATA, 32'd0);
        iINSTR_VALID = 1'b0;
        @(negedge iACLK);
        inRST = 1'b1;
        model_reset();

        for (int t = 0; t < NT; t++)
            for (int a = 0; a < DEPTH; a++) host_write(t, a, $urandom);

        // Host access basics, hold behaviour and out-of-range select.
        host_write(1, 0, 32'h1001);
        host_read_chk("host_rd_t1_a0", 1, 0, 32'h1001);
        idle_cycle();
        chk("host_rd_hold", oLMEM_RDATA, 32'h1001);
        host_write(5, 3, 32'hCAFE_F00D);
        host_read_chk("host_rd_bad_sel", 5, 3, 32'd0);
        host_read_chk("host_rd_t0_a3", 0, 3, m_mem[0][3]);

        // Shift chain with stores and a local load.
        issue(enc(4'd0, 5'd1, 1'b0, 5'd0, 17'd4), '0);
        issue(enc(4'd0, 5'd1, 1'b0, 5'd1, 17'd11), '0);
        for (int k = 0; k < 4; k++) begin
            issue(enc(4'd0, 5'd7, 1'b0, 5'd1, alu_f(5'd1, 5'd0)), '0);
            issue(enc(4'd0, 5'd10, 1'b0, 5'd0, ls_f(5'd1, 7'(3 + k), 5'd0)), '0);
        end
        issue(enc(4'd0, 5'd9, 1'b0, 5'd5, ls_f(5'd0, 7'd6, 5'd0)), '0);
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < 4; k++) host_read_chk("shift_store", t, 7 + k, exp_shift[k]);
        issue(enc(4'd0, 5'd10, 1'b0, 5'd0, ls_f(5'd5, 7'd40, 5'd0)), '0);
        for (int t = 0; t < NT; t++) host_read_chk("ldl_r5", t, 44, 32'd720896);

        // Host write and core store to the same word on one edge.
        ins = enc(4'd0, 5'd10, 1'b0, 5'd0, ls_f(5'd1, 7'd50, 5'd0));
        @(negedge iACLK);
        iINSTR = ins;
        iINSTR_VALID = 1'b1;
        iLMEM_THREAD_SEL = 8'd1;
        iLMEM_ADDR = 16'd54;
        iLMEM_WDATA = 32'hDEAD_BEEF;
        iLMEM_WR = 1'b1;
        @(posedge iACLK);
        #1;
        iINSTR_VALID = 1'b0;
        iLMEM_WR = 1'b0;
        m_mem[1][54] = 32'hDEAD_BEEF;
        model_exec(ins, '0);
        host_read_chk("collision_core_wins", 1, 54, 32'd720896);
        host_read_chk("collision_other_thread", 0, 54, 32'd720896);

        // Global load broadcast.
        issue(enc(4'd0, 5'd11, 1'b0, 5'd2, 17'd0), 32'h40);
        issue(enc(4'd0, 5'd10, 1'b0, 5'd0, ls_f(5'd2, 7'd30, 5'd0)), '0);
        for (int t = 0; t < NT; t++) host_read_chk("ldg_broadcast", t, 34, 32'h40);

        // Per-thread predication on the Z flag.
        issue(enc(4'd0, 5'd1, 1'b0, 5'd0, 17'd0), '0);
        issue(enc(4'd0, 5'd12, 1'b0, 5'd3, 17'd0), '0);
        issue(enc(4'd0, 5'd3, 1'b1, 5'd4, alu_f(5'd3, 5'd0)), '0);
        issue(enc(4'd1, 5'd1, 1'b0, 5'd6, 17'd7), '0);
        issue(enc(4'd1, 5'd10, 1'b0, 5'd0, ls_f(5'd6, 7'd20, 5'd0)), '0);
        host_read_chk("eq_store_t0", 0, 20, 32'd7);
        host_read_chk("eq_store_t1_kept", 1, 20, m_mem[1][20]);

        random_phase(300);
        dump_regs();
        compare_all_mem();

        // Reset in the middle of a local-load stall.
        @(negedge iACLK);
        iINSTR = enc(4'd0, 5'd9, 1'b0, 5'd7, ls_f(5'd0, 7'd1, 5'd0));
        iINSTR_VALID = 1'b1;
        @(posedge iACLK);
        #1;
        iINSTR_VALID = 1'b0;
        inRST = 1'b0;
        #1;
        chk("rst_stall_ready", 32'(oINSTR_READY), 32'd0);
        chk("rst_stall_idle", 32'(oIDLING), 32'd1);
        repeat (2) @(posedge iACLK);
        #1;
        chk("rst_stall_rdata", oLMEM_RDATA, 32'd0);
        chk("rst_stall_gmem_rd", 32'(oGMEM_RD), 32'd0);
        @(negedge iACLK);
        inRST = 1'b1;
        model_reset();
        dump_regs();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < 32; r++) host_read_chk("reg_zero_after_rst", t, r, 32'd0);

        random_phase(250);
        dump_regs();
        compare_all_mem();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gppcu_simd_core.md
GPPCU_SIMD_CORE -- requirements
Module: gppcu_simd_core

Interface
REQ-001 Parameter NUM_THREAD, default 24: number of lock-step SIMD threads (1..256).
REQ-002 Parameter WORD_BW, default 9: local-memory address width; 2^WORD_BW 32-bit words per thread.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-low. Clock port is iACLK; reset port is inRST.
REQ-004 iACLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 inRST  in  1  synchronous active-low reset.
REQ-006 iINSTR  in  32  instruction word.
REQ-007 iINSTR_VALID  in  1  iINSTR is valid.
REQ-008 oINSTR_READY  out  1  core accepts iINSTR this edge.
REQ-009 oIDLING  out  1  no instruction executing or stalled.
REQ-010 iLMEM_THREAD_SEL  in  8  host thread select.
REQ-011 iLMEM_ADDR  in  16  host word address; low WORD_BW bits used.
REQ-012 iLMEM_WDATA  in  32  host write data.
REQ-013 iLMEM_RD  in  1  host read strobe.
REQ-014 iLMEM_WR  in  1  host write strobe.
REQ-015 oLMEM_RDATA  out  32  host read data.
REQ-016 oGMEM_ADDR  out  17  global-memory address.
REQ-017 oGMEM_RD  out  1  one-cycle global-read strobe.
REQ-018 iGMEM_WDATA  in  32  global read data returned to the core.

Function
REQ-019 Per thread: 32 registers x 32 bits, flags Z and N, one local memory of 2^WORD_BW x 32 bits.
REQ-020 Encoding: [31:28] COND, [27:23] OPC, [22] S, [21:17] RD; imm17 = [16:0]; RA = [16:12], RB = [11:7]; for LDL/STL: RS = [16:12], OFS7 = [11:5], BASE = [4:0].
REQ-021 Opcodes: 0 NOP, 1 MVI (RD = zero-extended imm17), 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 LSL (RD = RA << RB[4:0]), 8 LSR (logical), 9 LDL (RD = lmem[R[BASE]+OFS7]), 10 STL (lmem[R[BASE]+OFS7] = R[RS]), 11 LDG (RD = global word at imm17), 12 TID (RD = thread index); codes 13..31 execute as NOP.
REQ-022 ALU results are 32-bit, modulo 2^32; LDL/STL addresses are the sum truncated to WORD_BW bits, so they wrap.
REQ-023 When S=1, ALU ops 2..8 update Z (result == 0) and N (result[31]); other ops never alter flags.
REQ-024 COND values: 0 ALWAYS, 1 EQ (Z), 2 NE (!Z), 3 MI (N), 4 PL (!N); other values act as ALWAYS. Evaluation is per thread; a false thread writes neither registers, flags nor memory.
REQ-025 Accept occurs on an edge where iINSTR_VALID and oINSTR_READY are both 1; with VALID=0, no architectural state changes.
REQ-026 Single-cycle ops complete on the accept edge; their result is visible to the next accepted instruction, with no hazards.
REQ-027 LDL and LDG deassert oINSTR_READY for exactly one cycle after accept, then write RD.
REQ-028 LDG drives oGMEM_ADDR = imm17 and pulses oGMEM_RD in the cycle after accept, samples iGMEM_WDATA at that cycle's end, and broadcasts the value to all enabled threads.
REQ-029 oIDLING = 1 iff no LDL/LDG stall is pending and iINSTR_VALID = 0.
REQ-030 Host write: lmem[SEL][ADDR] = WDATA on the edge. Host read: oLMEM_RDATA is registered and valid one cycle later, holding otherwise. A SEL >= NUM_THREAD writes nothing and reads 0.
REQ-031 When a host write and a core STL hit the same thread and address on the same edge, the core value wins.

Reset
REQ-032 While inRST = 0: all registers and flags are 0, the stall is cleared, oINSTR_READY = 0, oIDLING = 1, oGMEM_RD = 0, oGMEM_ADDR = 0, oLMEM_RDATA = 0.
REQ-033 Local memory contents are not reset. A reset during an LDL/LDG stall aborts the load with no register write.

Structure
REQ-034 Shared package gppcu_pkg holds the COND/OPC codes, field bit positions and the register-count constant.
REQ-035 One sub-module, gppcu_thread_lane (register file, flags, ALU, local memory), is instantiated NUM_THREAD times.

Verification
REQ-036 NUM_THREAD=2: host write thread1 addr0 = 0x1001, then read -> oLMEM_RDATA = 0x1001 one cycle later.
REQ-037 Run MVI r0,4; MVI r1,11; then four LSL r1,r1,r0 + STL r1,[r0+3..6] pairs, then LDL r5,[r0+6] -> in both threads lmem[7..10] = 176, 2816, 45056, 720896, r5 = 720896, and READY is low one cycle after the LDL.
REQ-038 Run LDG r2,0 with iGMEM_WDATA = 0x40 -> oGMEM_RD pulses with address 0, then STL r2 -> 0x40 stored in every thread.
REQ-039 Run MVI r0,0; TID r3; SUB S r4,r3,r0; EQ MVI r6,7; STL r6,[r0+20] -> lmem[20] = 7 in thread0 only; thread1 keeps its prior value.
REQ-040 Assert reset during an LDL stall -> READY = 0 and IDLE = 1; after release, all registers read 0 via STL.
